// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/response channel for alu_pipe.
//   Request : in_valid/in_ready handshake carrying in_op, in_a, in_b, in_tag.
//   Response: out_valid/out_ready handshake carrying out_data, out_tag,
//             out_zero, out_err.
//   flush   : synchronous abort, driven by the requester side.
// master = operand router / output register side, slave = the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_err;

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked CGRA processing-element ALU.
//   One op per request transaction; result, zero/err flags and the routing
//   tag are registered and presented on the response channel until taken.
//   Single-cycle ops complete one cycle after acceptance. Multiply (op 0010)
//   is an iterative shift-add over WIDTH cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_pipe_if.slave (request, response and flush)
// Configuration:
//   ALU_PIPE_MUL_EN - when defined, builds the multiplier and the BUSY state.
//                     When undefined, op 0010 completes in one cycle as a
//                     reserved op (data 0, err 1).
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_pipe_if.slave    bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_LTU  = 4'b0101;
    localparam logic [3:0] OP_GTU  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_LTS  = 4'b1100;
    localparam logic [3:0] OP_GTS  = 4'b1101;
    localparam logic [3:0] OP_PASS = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_PIPE_MUL_EN
        S_BUSY = 2'd2,
`endif
        S_HOLD = 2'd1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             err;
    } res_t;

    state_t           state;
    res_t             alu;
    logic [SH_W-1:0]  sh;
    logic             accept;

    // Combinational ready: a held result can be replaced in the same cycle
    // it is consumed, which gives full single-cycle throughput.
    assign bus.in_ready = !rst && !bus.flush &&
                          (state == S_IDLE || (state == S_HOLD && bus.out_ready));
    assign accept = bus.in_valid && bus.in_ready;

    // Single-cycle datapath. Reserved (and mul when not built) fall through
    // to the default: data 0, err 1.
    always_comb begin
        alu.data = '0;
        alu.err  = 1'b0;
        sh       = bus.in_b[SH_W-1:0];
        case (bus.in_op)
            OP_ADD:  alu.data = bus.in_a + bus.in_b;
            OP_SUB:  alu.data = bus.in_a - bus.in_b;
            OP_SLL:  alu.data = bus.in_a << sh;
            OP_SRL:  alu.data = bus.in_a >> sh;
            OP_LTU:  alu.data = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
            OP_GTU:  alu.data = {{(WIDTH-1){1'b0}}, (bus.in_a > bus.in_b)};
            OP_EQ:   alu.data = {{(WIDTH-1){1'b0}}, (bus.in_a == bus.in_b)};
            OP_AND:  alu.data = bus.in_a & bus.in_b;
            OP_OR:   alu.data = bus.in_a | bus.in_b;
            OP_XOR:  alu.data = bus.in_a ^ bus.in_b;
            OP_SRA:  alu.data = $signed(bus.in_a) >>> sh;
            OP_LTS:  alu.data = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            OP_GTS:  alu.data = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) > $signed(bus.in_b))};
            OP_PASS: alu.data = bus.in_a;
            default: alu.err  = 1'b1;
        endcase
        alu.zero = (alu.data == '0);
    end

`ifdef ALU_PIPE_MUL_EN
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [SH_W-1:0]  cnt;
    logic [TAG_W-1:0] mul_tag;

    // Only the low WIDTH bits are kept, so bits shifted out of mcand are
    // exactly the ones that would land above the result.
    assign acc_nxt = mplier[0] ? acc + mcand : acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_tag   <= '0;
            bus.out_zero  <= 1'b0;
            bus.out_err   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            cnt           <= '0;
            mul_tag       <= '0;
`endif
        end else if (bus.flush) begin
            // Output registers keep their contents; only validity is dropped.
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
        end else if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (bus.in_op == OP_MUL) begin
                // The tag is parked until the product lands so out_tag keeps
                // matching out_data meanwhile.
                mcand         <= bus.in_a;
                mplier        <= bus.in_b;
                acc           <= '0;
                cnt           <= '0;
                mul_tag       <= bus.in_tag;
                state         <= S_BUSY;
                bus.out_valid <= 1'b0;
            end else
`endif
            begin
                state         <= S_HOLD;
                bus.out_valid <= 1'b1;
                bus.out_data  <= alu.data;
                bus.out_tag   <= bus.in_tag;
                bus.out_zero  <= alu.zero;
                bus.out_err   <= alu.err;
            end
        end else begin
            case (state)
                S_HOLD: begin
                    if (bus.out_ready) begin
                        state         <= S_IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
`ifdef ALU_PIPE_MUL_EN
                S_BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state         <= S_HOLD;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= acc_nxt;
                        bus.out_tag   <= mul_tag;
                        bus.out_zero  <= (acc_nxt == '0);
                        bus.out_err   <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed + randomized bench for alu_pipe (WIDTH=32, TAG_W=4).
// Expected results come from a plain-arithmetic model of the opcode table.
module tb_alu_pipe;
    localparam int W  = 32;
    localparam int TW = 4;
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [TW-1:0] last_tag;

    alu_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: opcode table evaluated directly on 32-bit integers.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic e, output int lat);
        int unsigned s;
        s   = b % 32;
        d   = 0;
        e   = 0;
        lat = 1;
        case (op)
            0:  d = a + b;
            1:  d = a - b;
            2:  if (MUL_EN) begin d = a * b; lat = W + 1; end else e = 1;
            3:  d = a << s;
            4:  d = a >> s;
            5:  d = (a < b) ? 1 : 0;
            6:  d = (a > b) ? 1 : 0;
            7:  d = (a == b) ? 1 : 0;
            8:  d = a & b;
            9:  d = a | b;
            10: d = a ^ b;
            11: d = $unsigned($signed(a) >>> s);
            12: d = ($signed(a) < $signed(b)) ? 1 : 0;
            13: d = ($signed(a) > $signed(b)) ? 1 : 0;
            14: d = a;
            default: e = 1;
        endcase
    endfunction

    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TW-1:0] tag);
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
    endtask

    // Present a request and return just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tag);
        int n;
        set_in(op, a, b, tag);
        #1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        check("accept_wait", 64'(n < 100), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait for the response and compare against the model.
    task automatic finish_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [TW-1:0] tag);
        logic [31:0] d;
        logic        e;
        int          lat_exp;
        int          lat;
        model(op, a, b, d, e, lat_exp);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
        check($sformatf("lat op%0d", op), 64'(lat), 64'(lat_exp));
        check($sformatf("data op%0d", op), 64'(bus.out_data), 64'(d));
        check($sformatf("zero op%0d", op), 64'(bus.out_zero), 64'(d == 0));
        check($sformatf("err op%0d", op), 64'(bus.out_err), 64'(e));
        check($sformatf("tag op%0d", op), 64'(bus.out_tag), 64'(tag));
        last_tag = tag;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TW-1:0] tag);
        issue(op, a, b, tag);
        finish_op(op, a, b, tag);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        checks        = 0;
        errors        = 0;
        last_tag      = '0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        check("rst in_ready", 64'(bus.in_ready), 64'd0);
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst out_data", 64'(bus.out_data), 64'd0);
        check("rst out_tag", 64'(bus.out_tag), 64'd0);
        check("rst flags", 64'({bus.out_zero, bus.out_err}), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("idle in_ready", 64'(bus.in_ready), 64'd1);

        // Back-to-back single-cycle ops
        set_in(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd1);
        #1;
        check("b2b ready0", 64'(bus.in_ready), 64'd1);
        step();
        check("b2b add data", 64'(bus.out_data), 64'd0);
        check("b2b add zero", 64'(bus.out_zero), 64'd1);
        check("b2b add valid", 64'(bus.out_valid), 64'd1);
        set_in(4'd1, 32'd0, 32'd1, 4'd2);
        #1;
        check("b2b ready1", 64'(bus.in_ready), 64'd1);
        step();
        check("b2b sub data", 64'(bus.out_data), 64'hFFFF_FFFF);
        check("b2b sub tag", 64'(bus.out_tag), 64'd2);
        set_in(4'd12, 32'h8000_0000, 32'd1, 4'd3);
        step();
        check("b2b lts data", 64'(bus.out_data), 64'd1);
        check("b2b lts valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        last_tag = 4'd3;
        step();
        check("b2b drained", 64'(bus.out_valid), 64'd0);

        // Multiply wrap
        issue(4'd2, 32'h0001_0000, 32'h0001_0003, 4'd4);
        if (MUL_EN) begin
            check("busy in_ready", 64'(bus.in_ready), 64'd0);
            step();
            check("busy in_ready2", 64'(bus.in_ready), 64'd0);
            check("busy out_valid", 64'(bus.out_valid), 64'd0);
            finish_op(4'd2, 32'h0001_0000, 32'h0001_0003, 4'd4);
            check("mul wrap", 64'(bus.out_data), 64'h0003_0000);
        end else begin
            finish_op(4'd2, 32'h0001_0000, 32'h0001_0003, 4'd4);
        end
        step();

        // Backpressure
        bus.out_ready = 1'b0;
        issue(4'd4, 32'h8000_0000, 32'h21, 4'd5);
        finish_op(4'd4, 32'h8000_0000, 32'h21, 4'd5);
        set_in(4'd0, 32'd2, 32'd3, 4'd6);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp data", 64'(bus.out_data), 64'h4000_0000);
            check("bp valid", 64'(bus.out_valid), 64'd1);
            check("bp in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp release ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp next data", 64'(bus.out_data), 64'd5);
        check("bp next tag", 64'(bus.out_tag), 64'd6);
        last_tag = 4'd6;
        step();

        // Reserved op, then mul (reserved when the multiplier is not built)
        run_op(4'd15, 32'h1234_5678, 32'h9, 4'd7);
        check("rsv data", 64'(bus.out_data), 64'd0);
        check("rsv err", 64'(bus.out_err), 64'd1);
        run_op(4'd2, 32'd5, 32'd9, 4'd8);
        step();

        // Flush during BUSY (or during HOLD when mul is not built)
        if (MUL_EN) begin
            issue(4'd2, 32'd11, 32'd13, 4'd9);
            repeat (5) step();
            bus.flush = 1'b1;
            #1;
            check("flush busy ready", 64'(bus.in_ready), 64'd0);
            step();
            bus.flush = 1'b0;
            for (int i = 0; i < 40; i++) begin
                step();
                check("flush busy valid", 64'(bus.out_valid), 64'd0);
            end
            check("flush busy tag", 64'(bus.out_tag), 64'(last_tag));
        end else begin
            bus.out_ready = 1'b0;
            issue(4'd0, 32'd1, 32'd1, 4'd9);
            check("hold before flush", 64'(bus.out_valid), 64'd1);
            last_tag = 4'd9;
            bus.flush = 1'b1;
            step();
            bus.flush = 1'b0;
            bus.out_ready = 1'b1;
            check("flush hold valid", 64'(bus.out_valid), 64'd0);
            check("flush hold tag", 64'(bus.out_tag), 64'(last_tag));
        end

        // Flush with in_valid in IDLE
        bus.flush = 1'b1;
        set_in(4'd0, 32'd7, 32'd7, 4'd10);
        #1;
        check("flush idle ready", 64'(bus.in_ready), 64'd0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush idle valid", 64'(bus.out_valid), 64'd0);
        step();
        check("flush idle valid2", 64'(bus.out_valid), 64'd0);
        check("flush idle tag", 64'(bus.out_tag), 64'(last_tag));

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = $urandom_range(0, 40);
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 4'($urandom_range(0, 15)));
        end
        step();

        // Reset mid-mul
        issue(4'd2, 32'd7, 32'd6, 4'd12);
        repeat (9) step();
        rst = 1'b1;
        #1;
        check("rstmid ready", 64'(bus.in_ready), 64'd0);
        check("rstmid valid", 64'(bus.out_valid), 64'd0);
        check("rstmid data", 64'(bus.out_data), 64'd0);
        check("rstmid tag", 64'(bus.out_tag), 64'd0);
        check("rstmid flags", 64'({bus.out_zero, bus.out_err}), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("rstmid ready after", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 40; i++) begin
            step();
            check("rstmid no result", 64'(bus.out_valid), 64'd0);
        end
        check("rstmid data after", 64'(bus.out_data), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
